wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 221 ++++++++++++++++++++++
 tb/tb_wb_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: a 2-entry result FIFO drained into the register file, with load-data wait and halt hold.
// Optional pending-write hazard query (q_hit) is enabled by defining WB_HAZARD_QUERY_EN.
module wb_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        halt,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_ts,
    input  logic [3:0]  ex_dest,
    input  logic [15:0] ex_val,
    input  logic        ex_load,
    input  logic        mem_valid,
    input  logic [15:0] mem_data,
    output logic        wb_en,
    output logic        w_ts,
    output logic [3:0]  rd_sel,
    output logic [15:0] rd_val,
    output logic [3:0]  i_dest,
    output logic        busy,
    output logic        mem_err,
    input  logic        q_ts,
    input  logic [3:0]  q_sel,
    output logic        q_hit
);

    typedef struct packed {
        logic        ts;
        logic [3:0]  dest;
        logic [15:0] val;
        logic        load;
    } entry_t;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    entry_t      fifo_q [2];
    logic        rd_ptr_q;
    logic        wr_ptr_q;
    logic [1:0]  count_q;
    logic        full;
    logic        empty;
    entry_t      head;
    logic        push;

    state_t      state_q;
    state_t      state_d;

    logic        pop;
    logic [15:0] wr_val;
    logic        hold_load;
    logic        err_set;
    logic        hold_valid_q;
    logic [15:0] hold_data_q;

    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign head  = fifo_q[rd_ptr_q];

    // Gating with rst_n keeps the stage from advertising space while it is held in reset.
    assign ex_ready = rst_n && !full && !halt;
    assign push     = ex_valid && ex_ready;
    assign busy     = !empty || (state_q != IDLE);

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!halt && !empty && head.load) begin
                    state_d = LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                if (!halt && (mem_valid || hold_valid_q)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: output logic ----------------
    always_comb begin
        pop       = 1'b0;
        wr_val    = head.val;
        hold_load = 1'b0;
        err_set   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!halt && !empty && !head.load) begin
                    pop = 1'b1;
                end
                // Load data with nothing outstanding is a protocol error.
                err_set = mem_valid;
            end
            LOAD_WAIT: begin
                if (!halt) begin
                    if (hold_valid_q) begin
                        pop     = 1'b1;
                        wr_val  = hold_data_q;
                        err_set = mem_valid;
                    end else if (mem_valid) begin
                        pop    = 1'b1;
                        wr_val = mem_data;
                    end
                end else if (mem_valid) begin
                    if (hold_valid_q) begin
                        err_set = 1'b1;
                    end else begin
                        hold_load = 1'b1;
                    end
                end
            end
            default: begin
                pop = 1'b0;
            end
        endcase
    end

    // ---------------- FIFO control ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: FIFO storage is deliberately not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{ts: ex_ts, dest: ex_dest, val: ex_val, load: ex_load};
        end
    end

    // ---------------- Load-data hold register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= 16'h0000;
        end else if (hold_load) begin
            hold_valid_q <= 1'b1;
            hold_data_q  <= mem_data;
        end else if (pop) begin
            hold_valid_q <= 1'b0;
        end
    end

    // ---------------- Sticky error ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_err <= 1'b0;
        end else if (err_set) begin
            mem_err <= 1'b1;
        end
    end

    // ---------------- Register-file write port ----------------
    // Write fields only update on a pop, so they hold their last value while wb_en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en  <= 1'b0;
            w_ts   <= 1'b0;
            rd_sel <= 4'h0;
            rd_val <= 16'h0000;
            i_dest <= 4'h0;
        end else begin
            wb_en <= pop;
            if (pop) begin
                w_ts   <= head.ts;
                rd_sel <= head.dest;
                rd_val <= wr_val;
                i_dest <= head.dest;
            end
        end
    end

    // ---------------- Pending-write hazard query ----------------
`ifdef WB_HAZARD_QUERY_EN
    always_comb begin
        q_hit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (((count_q == 2'd2) || ((count_q == 2'd1) && (rd_ptr_q == 1'(i)))) &&
                (fifo_q[i].ts == q_ts) && (fifo_q[i].dest == q_sel)) begin
                q_hit = 1'b1;
            end
        end
    end
`else
    logic unused_query;
    assign unused_query = ^{q_ts, q_sel};
    assign q_hit        = 1'b0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: streaming, loads, backpressure, halt, errors, reset, query.
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        halt;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_ts;
    logic [3:0]  ex_dest;
    logic [15:0] ex_val;
    logic        ex_load;
    logic        mem_valid;
    logic [15:0] mem_data;
    logic        wb_en;
    logic        w_ts;
    logic [3:0]  rd_sel;
    logic [15:0] rd_val;
    logic [3:0]  i_dest;
    logic        busy;
    logic        mem_err;
    logic        q_ts;
    logic [3:0]  q_sel;
    logic        q_hit;

    int checks   = 0;
    int failures = 0;
    logic exp_hit;

    wb_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .halt      (halt),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_ts     (ex_ts),
        .ex_dest   (ex_dest),
        .ex_val    (ex_val),
        .ex_load   (ex_load),
        .mem_valid (mem_valid),
        .mem_data  (mem_data),
        .wb_en     (wb_en),
        .w_ts      (w_ts),
        .rd_sel    (rd_sel),
        .rd_val    (rd_val),
        .i_dest    (i_dest),
        .busy      (busy),
        .mem_err   (mem_err),
        .q_ts      (q_ts),
        .q_sel     (q_sel),
        .q_hit     (q_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic ts, input logic [3:0] d,
                         input logic [15:0] val, input logic ld);
        ex_valid = v;
        ex_ts    = ts;
        ex_dest  = d;
        ex_val   = val;
        ex_load  = ld;
    endtask

    task automatic check_write(input string tag, input logic ts, input logic [3:0] d,
                               input logic [15:0] val);
        check({tag, "_wb_en"},  32'(wb_en),  32'h1);
        check({tag, "_w_ts"},   32'(w_ts),   32'(ts));
        check({tag, "_rd_sel"}, 32'(rd_sel), 32'(d));
        check({tag, "_i_dest"}, 32'(i_dest), 32'(d));
        check({tag, "_rd_val"}, 32'(rd_val), 32'(val));
    endtask

    initial begin
        rst_n = 1'b0;
        halt = 1'b0;
        mem_valid = 1'b0;
        mem_data = 16'h0000;
        q_ts = 1'b0;
        q_sel = 4'h0;
        drive(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0);
`ifdef WB_HAZARD_QUERY_EN
        exp_hit = 1'b1;
`else
        exp_hit = 1'b0;
`endif

        // Reset state
        #12;
        check("rst_ex_ready", 32'(ex_ready), 32'h0);
        check("rst_wb_en",    32'(wb_en),    32'h0);
        check("rst_rd_val",   32'(rd_val),   32'h0);
        check("rst_busy",     32'(busy),     32'h0);
        check("rst_mem_err",  32'(mem_err),  32'h0);
        #10 rst_n = 1'b1;
        #1;
        check("post_rst_ex_ready", 32'(ex_ready), 32'h1);
        step();

        // Back-to-back non-loads: each write one cycle after its push
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 4'(i), 16'h0200 + 16'(i), 1'b0);
            step();
            if (i > 0) check_write("stream", 1'b0, 4'(i - 1), 16'h0200 + 16'(i - 1));
        end
        drive(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0);
        step();
        check_write("stream_last", 1'b0, 4'h3, 16'h0203);
        step();
        check("stream_idle_wb_en", 32'(wb_en), 32'h0);
        check("stream_hold_rd_val", 32'(rd_val), 32'h0203);
        check("stream_idle_busy", 32'(busy), 32'h0);

        // Load: data returns 3 cycles later
        drive(1'b1, 1'b1, 4'h5, 16'hAAAA, 1'b1);
        step();
        drive(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0);
        step();
        step();
        step();
        check("load_wait_wb_en", 32'(wb_en), 32'h0);
        check("load_wait_busy", 32'(busy), 32'h1);
        mem_valid = 1'b1;
        mem_data  = 16'hBEEF;
        step();
        mem_valid = 1'b0;
        check_write("load", 1'b1, 4'h5, 16'hBEEF);
        check("load_busy_after", 32'(busy), 32'h0);
        step();
        check("load_single_wb", 32'(wb_en), 32'h0);
        check("load_no_err", 32'(mem_err), 32'h0);

        // Load at head plus two non-loads; FIFO fills and backpressures
        drive(1'b1, 1'b0, 4'h1, 16'h0000, 1'b1);
        step();
        drive(1'b1, 1'b0, 4'h2, 16'h0022, 1'b0);
        #1 check("bp_ready_one", 32'(ex_ready), 32'h1);
        step();
        drive(1'b1, 1'b0, 4'h3, 16'h0033, 1'b0);
        #1 check("bp_ready_full", 32'(ex_ready), 32'h0);
        step();
        check("bp_still_full", 32'(ex_ready), 32'h0);
        check("bp_no_write", 32'(wb_en), 32'h0);
        mem_valid = 1'b1;
        mem_data  = 16'h1111;
        step();
        mem_valid = 1'b0;
        check_write("bp_load", 1'b0, 4'h1, 16'h1111);
        step();
        drive(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0);
        check_write("bp_nl2", 1'b0, 4'h2, 16'h0022);
        step();
        check_write("bp_nl3", 1'b0, 4'h3, 16'h0033);
        step();
        check("bp_done_wb_en", 32'(wb_en), 32'h0);
        check("bp_done_busy", 32'(busy), 32'h0);

        // Halt during LOAD_WAIT while data returns
        drive(1'b1, 1'b0, 4'h4, 16'h0000, 1'b1);
        step();
        drive(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0);
        step();
        halt      = 1'b1;
        mem_valid = 1'b1;
        mem_data  = 16'h1234;
        #1 check("halt_ex_ready", 32'(ex_ready), 32'h0);
        step();
        mem_valid = 1'b0;
        mem_data  = 16'h0000;
        check("halt_no_write1", 32'(wb_en), 32'h0);
        step();
        check("halt_no_write2", 32'(wb_en), 32'h0);
        check("halt_busy", 32'(busy), 32'h1);
        halt = 1'b0;
        step();
        check_write("halt_release", 1'b0, 4'h4, 16'h1234);
        check("halt_no_err", 32'(mem_err), 32'h0);
        step();
        check("halt_single_wb", 32'(wb_en), 32'h0);

        // Hazard query against a queued load entry
        drive(1'b1, 1'b0, 4'h7, 16'h0000, 1'b1);
        step();
        drive(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0);
        q_ts  = 1'b0;
        q_sel = 4'h7;
        #1 check("q_hit_match", 32'(q_hit), 32'(exp_hit));
        q_ts = 1'b1;
        #1 check("q_hit_ts_miss", 32'(q_hit), 32'h0);
        q_ts  = 1'b0;
        q_sel = 4'h6;
        #1 check("q_hit_dest_miss", 32'(q_hit), 32'h0);
        step();
        mem_valid = 1'b1;
        mem_data  = 16'h7777;
        step();
        mem_valid = 1'b0;
        check_write("q_load", 1'b0, 4'h7, 16'h7777);
        q_sel = 4'h7;
        #1 check("q_hit_after_pop", 32'(q_hit), 32'h0);
        step();

        // Spurious load data with empty FIFO -> sticky error
        mem_valid = 1'b1;
        mem_data  = 16'hDEAD;
        step();
        mem_valid = 1'b0;
        check("err_set", 32'(mem_err), 32'h1);
        check("err_no_write", 32'(wb_en), 32'h0);
        step();
        step();
        check("err_sticky", 32'(mem_err), 32'h1);
        rst_n = 1'b0;
        #2;
        check("err_rst_mem_err", 32'(mem_err), 32'h0);
        check("err_rst_w_ts",    32'(w_ts),    32'h0);
        check("err_rst_rd_sel",  32'(rd_sel),  32'h0);
        check("err_rst_rd_val",  32'(rd_val),  32'h0);
        check("err_rst_i_dest",  32'(i_dest),  32'h0);
        check("err_rst_ex_ready", 32'(ex_ready), 32'h0);
        rst_n = 1'b1;
        #1 check("err_rel_ex_ready", 32'(ex_ready), 32'h1);
        step();

        // Reset mid-LOAD_WAIT drops the load; later data is an error
        drive(1'b1, 1'b1, 4'h9, 16'h0000, 1'b1);
        step();
        drive(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0);
        step();
        check("lw_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #2;
        check("lw_rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        #1;
        mem_valid = 1'b1;
        mem_data  = 16'h5555;
        step();
        mem_valid = 1'b0;
        check("lw_err", 32'(mem_err), 32'h1);
        check("lw_no_write", 32'(wb_en), 32'h0);
        check("lw_rd_val_kept", 32'(rd_val), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
